// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier for MULT/MULTU.
// Operands are widened by one bit, so a single datapath handles both
// two's-complement and unsigned products. The result is exact in 2*WIDTH bits.
// Latency is fixed at WIDTH+1 iterations after the start-sampling edge.
//
// Handshake: start acts as a request that is only taken while IDLE. busy low
// means "ready to accept". The cycle after an accepting edge, busy rises and
// stays high for exactly WIDTH+1 edges. Any start seen while busy is ignored.
// done pulses for one cycle in the first IDLE cycle after completion, and
// hi/lo are valid from that cycle on. A start in the done cycle is accepted,
// so operations can run back to back with no dead cycle. busy and done are
// never high together. hi/lo change only on completion or reset.
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             o_dbg_state
);

  // The working register holds {upper accumulator (WIDTH+1), multiplier
  // (WIDTH+1), Booth guard bit}.
  localparam int PW = 2 * WIDTH + 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [PW-1:0]    r_a;
  logic [PW-1:0]    r_p;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_ext_a;
  logic [WIDTH:0]   w_ext_b;
  logic             w_accept;
  logic             w_last;
  logic [PW-1:0]    w_p_sum;
  logic [PW-1:0]    w_p_shift;

  // Widen operands by one bit: sign-extend for signed mode, zero-extend otherwise.
  assign w_ext_a  = {is_signed & input_a[WIDTH-1], input_a};
  assign w_ext_b  = {is_signed & input_b[WIDTH-1], input_b};

  // A request is taken only from IDLE. The final iteration runs when the
  // counter reaches WIDTH.
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_CNT);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on an accepted start, RUN -> IDLE after the last iteration.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (w_last)   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: busy follows RUN. State is exported for observation.
  always_comb begin
    busy        = (r_state == S_RUN);
    done        = r_done;
    hi          = r_hi;
    lo          = r_lo;
    o_dbg_state = r_state;
  end

  // One Booth step: choose add, subtract or pass from the two low bits.
  // Then arithmetic-shift right by one. No separate sign patch is needed,
  // because the operands carry an extra bit.
  always_comb begin
    w_p_sum = r_p;
    unique case (r_p[1:0])
      2'b01:   w_p_sum = r_p + r_a;
      2'b10:   w_p_sum = r_p - r_a;
      default: w_p_sum = r_p;
    endcase
    w_p_shift = {w_p_sum[PW-1], w_p_sum[PW-1:1]};
  end

  // Datapath registers: load on accept, iterate while running. Reset clears
  // them so an aborted operation leaves nothing behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= {w_ext_a, {(WIDTH + 2){1'b0}}};
      r_p   <= {{(WIDTH + 1){1'b0}}, w_ext_b, 1'b0};
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_p   <= w_p_shift;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Result registers: capture the low 2*WIDTH product bits on the final
  // iteration and pulse done. Otherwise hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_hi <= w_p_shift[2*WIDTH:WIDTH+1];
        r_lo <= w_p_shift[WIDTH:1];
      end
    end
  end

`ifndef SYNTHESIS
  // busy and done are mutually exclusive by construction.
  a_busy_done_excl : assert property (@(posedge clock) disable iff (!reset)
    !(busy && done));

  // done is only ever preceded by a running cycle.
  a_done_after_run : assert property (@(posedge clock) disable iff (!reset)
    done |-> $past(r_state == S_RUN));
`endif

endmodule
